// File: rtl/gray_run_ctrl.sv
// Run-length sequencer for the 3-bit Gray counter: clears it, enables it for N
// cycles, counts wraps and cross-checks the counter's sticky overflow flag.
module gray_run_ctrl #(
   parameter int STEP_W = 8,
   parameter int WRAP_W = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [STEP_W-1:0] Steps,
   input  logic              Abort,
   input  logic [2:0]        CntOut,
   input  logic              CntOverflow,
   output logic              CntReset,
   output logic              CntEn,
   output logic              Busy,
   output logic              Done,
   output logic              Aborted,
   output logic [2:0]        Result,
   output logic [WRAP_W-1:0] Wraps,
   output logic              Err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0] WRAP_ZERO = {WRAP_W{1'b0}};
   localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};
   localparam logic [2:0]        GRAY_LAST = 3'b100;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] remaining_q, remaining_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic [2:0]        result_q, result_d;
   logic              aborted_q, aborted_d;
   logic              err_q, err_d;

   // Next-state and datapath decode for the run sequencer.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wraps_d     = wraps_q;
      result_d    = result_q;
      aborted_d   = 1'b0;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (Steps != STEP_ZERO) begin
                  remaining_d = Steps;
                  wraps_d     = WRAP_ZERO;
                  state_d     = ST_CLEAR;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (Abort) begin
               aborted_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (Abort) begin
               aborted_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               remaining_d = remaining_q - STEP_ONE;
               // The step taken from the last code is the one that wraps.
               if ((CntOut == GRAY_LAST) && (wraps_q != WRAP_MAX)) begin
                  wraps_d = wraps_q + WRAP_ONE;
               end else begin
                  wraps_d = wraps_q;
               end
               if (remaining_q == STEP_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            result_d = CntOut;
            err_d    = err_q | ((wraps_q != WRAP_ZERO) != CntOverflow);
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= STEP_ZERO;
         wraps_q     <= WRAP_ZERO;
         result_q    <= 3'b000;
         aborted_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wraps_q     <= wraps_d;
         result_q    <= result_d;
         aborted_q   <= aborted_d;
         err_q       <= err_d;
      end
   end

   // Counter enable is decoded directly so an abort never lets one more step through.
   assign CntReset = Reset | (state_q == ST_CLEAR);
   assign CntEn    = (state_q == ST_RUN) & ~Abort & ~Reset;
   assign Busy     = (state_q == ST_CLEAR) | (state_q == ST_RUN);
   assign Done     = (state_q == ST_DONE);
   assign Aborted  = aborted_q;
   assign Result   = (state_q == ST_DONE) ? CntOut : result_q;
   assign Wraps    = wraps_q;
   assign Err      = err_q;

endmodule

// File: doc/gray_run_ctrl.md
Name: gray_run_ctrl

Overview:
Sequencer for the team's 3-bit Gray counter (ports Clk/Reset/En/Output[2:0]/Overflow). It accepts a "run N steps" command with a Start/Busy/Done handshake and clears the counter. It then enables the counter for exactly N cycles, counts wrap-arounds, and reports the final code. It also cross-checks the counter's sticky Overflow flag against its own wrap count. It sits beside the counter instance and owns the counter's Reset and En inputs.

Parameters:
STEP_W, 8, width of the step-count command
WRAP_W, 4, width of the saturating wrap counter

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
Start  in  1  command strobe; sampled only in IDLE
Steps  in  STEP_W  number of Gray steps to run; latched with Start
Abort  in  1  cancel the run in progress
CntOut  in  3  counter Output
CntOverflow  in  1  counter Overflow (sticky; cleared only by counter reset)
CntReset  out  1  drives counter Reset
CntEn  out  1  drives counter En
Busy  out  1  high in CLEAR and RUN
Done  out  1  one-cycle completion pulse
Aborted  out  1  one-cycle abort pulse
Result  out  3  final Gray code of the last completed run
Wraps  out  WRAP_W  wraps in the current/last run, saturating at 2^WRAP_W-1
Err  out  1  sticky overflow-mismatch flag

Behaviour:
- Counter contract: on each edge with En=1, the counter steps 000→001→011→010→110→111→101→100→000. A wrap is the 100→000 step, and it sets Overflow. Counter Reset zeroes Output and Overflow.
- Interface decision: one clock, Clk. Reset is synchronous and active-high. On Reset the following apply:
  - state=IDLE.
  - Busy, Done, Aborted, CntEn, Err = 0.
  - Result = 000 and Wraps = 0.
  - Remaining-step register = 0.
- CntReset = Reset | (state==CLEAR). Counter is therefore cleared whenever the controller is reset.
- CntEn = (state==RUN) & ~Abort. This decode is combinational, so an abort causes no extra step.
- States: IDLE, CLEAR, RUN, DONE.
  - IDLE, Start=1, Steps!=0: latch Steps into remaining, Wraps←0, go to CLEAR.
  - IDLE, Start=1, Steps==0: go to DONE. No clear and no steps. Result = current CntOut; Wraps is unchanged.
  - CLEAR (1 cycle): CntReset=1, then go to RUN.
  - RUN, each cycle without Abort:
    - Decrement remaining.
    - If CntOut==100, Wraps←Wraps+1, saturating.
    - If remaining==1, go to DONE.
  - DONE (1 cycle): Done=1, Result register←CntOut, Err←Err | ((Wraps!=0) != CntOverflow), then go to IDLE.
  - Result output = CntOut while in DONE, otherwise the held register, so Result is valid in the same cycle as Done.
  - Abort in CLEAR or RUN: go to IDLE next edge and pulse Aborted for 1 cycle. Result is unchanged; Wraps holds its partial count. Abort in IDLE or DONE is ignored.
- Timing: Start sampled at edge t → CLEAR during t+1 → RUN for N cycles → Done high in cycle t+N+2. Busy is high for exactly N+1 cycles.
- Start while Busy or in DONE is ignored; there is no queueing.
- Simultaneous Start and Abort in IDLE: Start wins.
- Reset mid-run overrides everything: IDLE next cycle, counter cleared, no Done or Aborted pulse.
- Err is cleared only by Reset.

Test Plan:
- Reset asserted for 2 cycles, then released → all outputs 0, CntReset=1 during reset, CntEn=0.
- Start with Steps=5 → Busy for 6 cycles, CntEn for exactly 5 cycles, Done in cycle t+7, Result=111, Wraps=0, Err=0.
- Start with Steps=8, then Steps=19 → Result=000 with Wraps=1; then Result=010 (gray of 3) with Wraps=2; Err=0 both times.
- Steps=255 with WRAP_W=2 → Wraps saturates at 3 (31 wraps occur), Result=100.
- Start with Steps=20, Abort on the 4th RUN cycle → exactly 3 steps (CntOut=010), Aborted pulses once, no Done, Result keeps its prior value. A Start pulsed mid-run is ignored.
- Model forces CntOverflow=0 while a 9-step run wraps → Err=1 after Done, and Err stays 1 until Reset. Start with Steps=0 → Done in cycle t+1, CntEn never asserted.
